// File: rtl/cache_req_gen.sv
// CPU-side request generator for the cache CPU port.
// Commands are queued in a small FIFO, issued one at a time on
// cpu_to_cache, and read data is optionally checked against the queued
// expected value. Completion, error and timeout statistics are kept
// for self-test reporting.

package cache_req_gen_pkg;

   // CPU -> cache request bundle
   typedef struct packed {
      logic [19:0] addr;
      logic [31:0] data;
      logic        rw;
      logic        valid;
   } cpu_to_cache_type;

   // cache -> CPU response bundle
   typedef struct packed {
      logic [31:0] data;
      logic        ready;
   } cache_to_cpu_type;

   // request sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } req_state_t;

   // one queued command
   typedef struct packed {
      logic        rw;
      logic        check;
      logic [19:0] addr;
      logic [31:0] data;
   } cmd_entry_t;

endpackage

// Handshake semantics: a request is offered while cpu_to_cache.valid is
// high and its fields are held stable until the cache accepts it. The
// transfer happens at a rising edge where valid and ready are both high;
// ready seen while valid is low carries no meaning and is ignored. The
// command port follows the same rule: a command is taken at an edge
// where cmd_valid and cmd_ready are both high.
module cache_req_gen
   import cache_req_gen_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int TIMEOUT  = 64,
   parameter int IDLE_GAP = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_rw,
   input  logic [19:0]      cmd_addr,
   input  logic [31:0]      cmd_data,
   input  logic             cmd_check,
   output cpu_to_cache_type cpu_to_cache,
   input  cache_to_cpu_type cache_to_cpu,
   output logic             busy,
   output logic [15:0]      done_count,
   output logic [15:0]      err_count,
   output logic             timeout,
   output logic [19:0]      first_err_addr,
   output logic [31:0]      first_err_data
);

   localparam int AW          = $clog2(DEPTH);
   localparam int TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GW          = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
   localparam int TO_LAST_I   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam int GAP_LAST_I  = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;
   localparam logic [TW-1:0] TO_LAST  = TW'(TO_LAST_I);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LAST_I);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [15:0]   SAT      = 16'hFFFF;

   // ---------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------
   cmd_entry_t        mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop;
   cmd_entry_t        head;
   cmd_entry_t        wr_entry;

   // ---------------------------------------------------------------
   // Sequencer state and request registers
   // ---------------------------------------------------------------
   req_state_t        state;
   req_state_t        state_nxt;
   logic [TW-1:0]     wait_cnt;
   logic [GW-1:0]     gap_cnt;
   logic              req_rw;
   logic              req_check;
   logic [19:0]       req_addr;
   logic [31:0]       req_data;
   logic [31:0]       req_exp;

   logic              in_issue;
   logic              rdy;
   logic              issue;
   logic              complete;
   logic              tmo_hit;
   logic              finish;
   logic              rd_mismatch;
   logic              err_event;

   // Full/empty come from the registered count only, so a pop in the
   // same cycle never opens a slot for a push, and a push into an empty
   // FIFO is not visible to the sequencer until the next cycle.
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign push       = cmd_valid && !fifo_full;
   assign pop        = issue;
   assign head       = mem[rd_ptr];

   assign wr_entry.rw    = cmd_rw;
   assign wr_entry.check = cmd_check;
   assign wr_entry.addr  = cmd_addr;
   assign wr_entry.data  = cmd_data;

   // Request-level events. A ready on the timeout boundary wins: tmo_hit
   // is only raised when ready is low.
   assign in_issue    = (state == ST_ISSUE);
   assign rdy         = cache_to_cpu.ready;
   assign issue       = (state == ST_IDLE) && !fifo_empty && en;
   assign complete    = in_issue && rdy;
   assign tmo_hit     = in_issue && !rdy && (TIMEOUT != 0) && (wait_cnt == TO_LAST);
   assign finish      = complete || tmo_hit;
   assign rd_mismatch = complete && !req_rw && req_check &&
                        (cache_to_cpu.data != req_exp);
   assign err_event   = rd_mismatch || tmo_hit;

   // FIFO storage write; contents need no reset since occupancy guards reads
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Sequencer next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (issue) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (finish) begin
               state_nxt = (IDLE_GAP > 0) ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Sequencer outputs: valid is simply "in ISSUE", fields come from the
   // registers captured at issue time so they stay stable while waiting
   always_comb begin
      cpu_to_cache       = '0;
      cpu_to_cache.valid = in_issue;
      cpu_to_cache.rw    = req_rw;
      cpu_to_cache.addr  = req_addr;
      cpu_to_cache.data  = req_data;
      cmd_ready          = !fifo_full;
      busy               = !fifo_empty || (state != ST_IDLE);
   end

   // Request capture, wait/gap counters and statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         req_rw         <= 1'b0;
         req_check      <= 1'b0;
         req_addr       <= '0;
         req_data       <= '0;
         req_exp        <= '0;
         wait_cnt       <= '0;
         gap_cnt        <= '0;
         done_count     <= '0;
         err_count      <= '0;
         timeout        <= 1'b0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else begin
         if (issue) begin
            req_rw    <= head.rw;
            req_check <= head.check;
            req_addr  <= head.addr;
            req_data  <= head.rw ? head.data : 32'h0;
            req_exp   <= head.data;
         end

         if (issue || finish) begin
            wait_cnt <= '0;
         end else if (in_issue) begin
            wait_cnt <= wait_cnt + TW'(1);
         end

         if (state == ST_GAP) begin
            gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GW'(1);
         end else begin
            gap_cnt <= '0;
         end

         if (complete && (done_count != SAT)) begin
            done_count <= done_count + 16'd1;
         end

         if (err_event) begin
            if (err_count != SAT) begin
               err_count <= err_count + 16'd1;
            end
            // err_count never returns to zero outside reset, so zero
            // marks the first error
            if (err_count == '0) begin
               first_err_addr <= req_addr;
               first_err_data <= tmo_hit ? 32'h0 : cache_to_cpu.data;
            end
         end

         if (tmo_hit) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache_req_gen.sv
// Directed bench for cache_req_gen: writes, checked reads, FIFO full,
// timeout, back-to-back issue, reset mid-request, plus an idle-gap /
// timeout-disabled instance.
module tb_cache_req_gen;
   import cache_req_gen_pkg::*;

   logic             clk;
   logic             rst;

   logic             en;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_rw;
   logic [19:0]      cmd_addr;
   logic [31:0]      cmd_data;
   logic             cmd_check;
   cpu_to_cache_type cpu;
   cache_to_cpu_type c2c;
   logic             busy;
   logic [15:0]      done_count;
   logic [15:0]      err_count;
   logic             timeout;
   logic [19:0]      first_err_addr;
   logic [31:0]      first_err_data;

   logic             g_en;
   logic             g_cmd_valid;
   logic             g_cmd_ready;
   logic             g_cmd_rw;
   logic [19:0]      g_cmd_addr;
   logic [31:0]      g_cmd_data;
   logic             g_cmd_check;
   cpu_to_cache_type g_cpu;
   cache_to_cpu_type g_c2c;
   logic             g_busy;
   logic [15:0]      g_done_count;
   logic [15:0]      g_err_count;
   logic             g_timeout;
   logic [19:0]      g_first_err_addr;
   logic [31:0]      g_first_err_data;

   int total = 0;
   int bad   = 0;

   cache_req_gen #(.DEPTH(8), .TIMEOUT(16), .IDLE_GAP(0)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_rw         (cmd_rw),
      .cmd_addr       (cmd_addr),
      .cmd_data       (cmd_data),
      .cmd_check      (cmd_check),
      .cpu_to_cache   (cpu),
      .cache_to_cpu   (c2c),
      .busy           (busy),
      .done_count     (done_count),
      .err_count      (err_count),
      .timeout        (timeout),
      .first_err_addr (first_err_addr),
      .first_err_data (first_err_data)
   );

   cache_req_gen #(.DEPTH(4), .TIMEOUT(0), .IDLE_GAP(2)) dut_gap (
      .clk            (clk),
      .rst            (rst),
      .en             (g_en),
      .cmd_valid      (g_cmd_valid),
      .cmd_ready      (g_cmd_ready),
      .cmd_rw         (g_cmd_rw),
      .cmd_addr       (g_cmd_addr),
      .cmd_data       (g_cmd_data),
      .cmd_check      (g_cmd_check),
      .cpu_to_cache   (g_cpu),
      .cache_to_cpu   (g_c2c),
      .busy           (g_busy),
      .done_count     (g_done_count),
      .err_count      (g_err_count),
      .timeout        (g_timeout),
      .first_err_addr (g_first_err_addr),
      .first_err_data (g_first_err_data)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one command push; called and returns on a falling edge
   task automatic push(input logic rw, input logic [19:0] a, input logic [31:0] d,
                       input logic ck);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_check = ck;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic g_push(input logic rw, input logic [19:0] a, input logic [31:0] d);
      g_cmd_valid = 1'b1;
      g_cmd_rw    = rw;
      g_cmd_addr  = a;
      g_cmd_data  = d;
      g_cmd_check = 1'b0;
      @(negedge clk);
      g_cmd_valid = 1'b0;
   endtask

   initial begin
      logic [4:0] gap_pat;
      rst = 1'b1; en = 1'b0;
      cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_check = 1'b0;
      c2c = '0;
      g_en = 1'b0;
      g_cmd_valid = 1'b0; g_cmd_rw = 1'b0; g_cmd_addr = '0; g_cmd_data = '0; g_cmd_check = 1'b0;
      g_c2c = '0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_cpu", cpu, 64'h0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_fe_addr", first_err_addr, 0);
      chk("rst_fe_data", first_err_data, 0);
      chk("rst_g_cpu", g_cpu, 64'h0);
      rst = 1'b0;

      // write, ready 3 cycles after valid -> valid high 4 cycles
      en = 1'b1;
      push(1'b1, 20'h00004, 32'h00000004, 1'b0);
      chk("wr_no_early_valid", cpu.valid, 0);
      chk("wr_busy_queued", busy, 1);
      @(negedge clk);
      chk("wr_issue", cpu, {20'h00004, 32'h00000004, 1'b1, 1'b1});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wr_hold", cpu, {20'h00004, 32'h00000004, 1'b1, 1'b1});
      end
      c2c.ready = 1'b1;
      @(negedge clk);
      c2c.ready = 1'b0;
      chk("wr_valid_low", cpu.valid, 0);
      chk("wr_done", done_count, 1);
      chk("wr_err", err_count, 0);
      chk("wr_busy_idle", busy, 0);

      // checked read, matching data
      push(1'b0, 20'h0000C, 32'h0000000C, 1'b1);
      @(negedge clk);
      chk("rd_issue", cpu, {20'h0000C, 32'h0, 1'b0, 1'b1});
      c2c.data = 32'h0000000C; c2c.ready = 1'b1;
      @(negedge clk);
      c2c = '0;
      chk("rd_ok_done", done_count, 2);
      chk("rd_ok_err", err_count, 0);

      // checked read, mismatching data
      push(1'b0, 20'h0000C, 32'h0000000C, 1'b1);
      @(negedge clk);
      c2c.data = 32'h0008000C; c2c.ready = 1'b1;
      @(negedge clk);
      c2c = '0;
      chk("rd_bad_done", done_count, 3);
      chk("rd_bad_err", err_count, 1);
      chk("rd_bad_fe_addr", first_err_addr, 20'h0000C);
      chk("rd_bad_fe_data", first_err_data, 32'h0008000C);

      // full FIFO with issue disabled
      en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         push(1'b1, 20'h00100 + 20'(4 * i), 32'(i), 1'b0);
      end
      chk("full_ready_low", cmd_ready, 0);
      chk("full_no_issue", cpu.valid, 0);
      push(1'b1, 20'h00999, 32'hDEAD, 1'b0);
      chk("full_held_off", cmd_ready, 0);
      en = 1'b1;
      @(negedge clk);
      chk("full_ready_after_pop", cmd_ready, 1);
      c2c.ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("full_order", {cpu.valid, cpu.addr, cpu.data}, {1'b1, 20'h00100 + 20'(4 * i), 32'(i)});
         @(negedge clk);
         chk("full_low", cpu.valid, 0);
         @(negedge clk);
      end
      c2c.ready = 1'b0;
      chk("full_drained_valid", cpu.valid, 0);
      chk("full_drained_busy", busy, 0);
      chk("full_done", done_count, 11);

      // plain reset to clear statistics
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_done", done_count, 0);
      chk("rst2_fe_addr", first_err_addr, 0);

      // timeout, next queued command issued afterwards
      push(1'b1, 20'h00200, 32'h000000AA, 1'b0);
      push(1'b1, 20'h00204, 32'h000000BB, 1'b0);
      chk("to_issue", cpu, {20'h00200, 32'h000000AA, 1'b1, 1'b1});
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("to_hold", cpu.valid, 1);
      end
      @(negedge clk);
      chk("to_valid_low", cpu.valid, 0);
      chk("to_flag", timeout, 1);
      chk("to_err", err_count, 1);
      chk("to_fe_addr", first_err_addr, 20'h00200);
      chk("to_fe_data", first_err_data, 0);
      chk("to_done", done_count, 0);
      @(negedge clk);
      chk("to_next_issue", cpu, {20'h00204, 32'h000000BB, 1'b1, 1'b1});
      c2c.ready = 1'b1;
      @(negedge clk);
      c2c.ready = 1'b0;
      chk("to_next_done", done_count, 1);
      chk("to_sticky", timeout, 1);
      chk("to_busy", busy, 0);

      // back-to-back writes with ready tied high
      en = 1'b0;
      c2c.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(1'b1, 20'(4 * i), 32'h10 + 32'(i), 1'b0);
      end
      en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k % 2 == 1) begin
            chk("b2b_high", {cpu.valid, cpu.addr}, {1'b1, 20'(4 * ((k - 1) / 2))});
         end else begin
            chk("b2b_low", cpu.valid, 0);
         end
      end
      chk("b2b_done", done_count, 5);
      chk("b2b_busy", busy, 0);
      c2c.ready = 1'b0;

      // reset while a request is in flight with 3 more queued
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(1'b1, 20'h00300 + 20'(4 * i), 32'h55 + 32'(i), 1'b0);
      end
      en = 1'b1;
      @(negedge clk);
      chk("mid_issue", {cpu.valid, cpu.addr}, {1'b1, 20'h00300});
      rst = 1'b1;
      @(negedge clk);
      chk("mid_cpu", cpu, 64'h0);
      chk("mid_cmd_ready", cmd_ready, 1);
      chk("mid_busy", busy, 0);
      chk("mid_done", done_count, 0);
      chk("mid_err", err_count, 0);
      chk("mid_timeout", timeout, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_no_stale", {cpu.valid, busy}, 0);
      end

      // idle gap of 2: valid pattern 1,0,0,0,1
      g_c2c.ready = 1'b1;
      g_push(1'b1, 20'h00040, 32'h1);
      g_push(1'b1, 20'h00044, 32'h2);
      g_en = 1'b1;
      gap_pat = 5'b10001;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("gap_pattern", g_cpu.valid, gap_pat[k]);
         if (k == 4) begin
            chk("gap_second_addr", g_cpu.addr, 20'h00044);
         end
      end
      @(negedge clk);
      chk("gap_done", g_done_count, 2);

      // timeout disabled: request waits indefinitely
      g_c2c.ready = 1'b0;
      g_push(1'b0, 20'h00048, 32'h0);
      for (int w = 0; w < 10 && !g_cpu.valid; w++) begin
         @(negedge clk);
      end
      chk("notmo_issue", {g_cpu.valid, g_cpu.addr}, {1'b1, 20'h00048});
      repeat (70) @(negedge clk);
      chk("notmo_hold", g_cpu.valid, 1);
      chk("notmo_flag", g_timeout, 0);
      g_c2c.data = 32'h1234; g_c2c.ready = 1'b1;
      @(negedge clk);
      g_c2c = '0;
      chk("notmo_done", g_done_count, 3);
      chk("nocheck_err", g_err_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
